usb2_line_state_filter: RTL

//  Conditions raw D+/D- receiver levels into clean, debounced USB line states.

---
 rtl/usb2_phy_pkg.sv | 27 ++
 rtl/usb2_sync_2ff.sv | 33 +++
 rtl/usb2_line_state_filter.sv | 116 +++++++++++
 3 files changed

// File: rtl/usb2_phy_pkg.sv
// Line-state encoding and default 48 MHz timing shared by the USB2 PHY
// line-state filter and the chirp handler.
package usb2_phy_pkg;

    typedef enum logic [1:0] {
        LS_SE0  = 2'b00,
        LS_FS_J = 2'b01,
        LS_FS_K = 2'b10,
        LS_SE1  = 2'b11
    } linestate_e;

    localparam int DEF_TIMER_W        = 24;
    localparam int DEF_FILTER_CYCLES  = 3;
    localparam int DEF_RESET_CYCLES   = 120;     // 2.5 us
    localparam int DEF_CHIRP_CYCLES   = 120;     // 2.5 us
    localparam int DEF_SUSPEND_CYCLES = 144000;  // 3 ms

    // Low-speed signalling swaps the J and K polarities on the wire.
    function automatic logic is_j(input linestate_e ls, input logic ls_mode);
        return ls_mode ? (ls == LS_FS_K) : (ls == LS_FS_J);
    endfunction

    function automatic logic is_k(input linestate_e ls, input logic ls_mode);
        return ls_mode ? (ls == LS_FS_J) : (ls == LS_FS_K);
    endfunction

endpackage

// File: rtl/usb2_sync_2ff.sv
// Two-flop synchronizer for asynchronous receiver levels; resets to all zeros.
module usb2_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    // NOTE: non-blocking assignments make both stages sample the pre-edge
    // values; blocking here would collapse the chain into a single flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/usb2_line_state_filter.sv
// Debounces synchronized D+/D- into a clean line state and times how long
// that state has been held, flagging bus reset, suspend and chirp K/J.
module usb2_line_state_filter
    import usb2_phy_pkg::*;
#(
    parameter int TIMER_W        = DEF_TIMER_W,
    parameter int FILTER_CYCLES  = DEF_FILTER_CYCLES,
    parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int CHIRP_CYCLES   = DEF_CHIRP_CYCLES,
    parameter int SUSPEND_CYCLES = DEF_SUSPEND_CYCLES
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_dp,
    input  logic       i_dn,
    input  logic       i_ls_mode,
    input  logic       i_hs_mode,
    input  logic       i_chirp_en,
    output logic [1:0] o_linestate,
    output logic       o_se0,
    output logic       o_j_state,
    output logic       o_k_state,
    output logic       o_se1,
    output logic       o_line_change,
    output logic       o_reset_det,
    output logic       o_suspend_det,
    output logic       o_chirp_k,
    output logic       o_chirp_j
);

    localparam int FILT_W = $clog2(FILTER_CYCLES + 2);

    localparam logic [TIMER_W-1:0] RESET_TH   = TIMER_W'(RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CHIRP_TH   = TIMER_W'(CHIRP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SUSPEND_TH = TIMER_W'(SUSPEND_CYCLES - 1);

    logic [1:0]         sync_pair;
    logic [1:0]         prev_q, prev_d;
    logic [FILT_W-1:0]  filt_cnt_q, filt_cnt_d;
    linestate_e         linestate_q, linestate_d;
    logic [TIMER_W-1:0] dur_q, dur_d;
    logic               line_change_q, line_change_d;
    logic               sync_changed;
    logic               accept;
    int                 stable_len;

    usb2_sync_2ff #(.WIDTH(2)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   ({i_dn, i_dp}),
        .o_q   (sync_pair)
    );

    // NOTE: every signal written here gets a value on every path, so no
    // latch can be inferred.
    always_comb begin
        sync_changed = (sync_pair != prev_q);
        prev_d       = sync_pair;

        if (sync_changed) begin
            filt_cnt_d = '0;
        end else if (&filt_cnt_q) begin
            filt_cnt_d = filt_cnt_q;
        end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
        end

        // Samples of the current synced pair seen so far, including this one.
        stable_len = sync_changed ? 1 : int'(filt_cnt_q) + 2;
        accept     = (stable_len >= FILTER_CYCLES) && (sync_pair != linestate_q);

        linestate_d   = accept ? linestate_e'(sync_pair) : linestate_q;
        line_change_d = accept;

        if (accept) begin
            dur_d = '0;
        end else if (&dur_q) begin
            dur_d = dur_q;
        end else begin
            dur_d = dur_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_q        <= '0;
            filt_cnt_q    <= '0;
            linestate_q   <= LS_SE0;
            dur_q         <= '0;
            line_change_q <= 1'b0;
        end else begin
            prev_q        <= prev_d;
            filt_cnt_q    <= filt_cnt_d;
            linestate_q   <= linestate_d;
            dur_q         <= dur_d;
            line_change_q <= line_change_d;
        end
    end

    // Decode and thresholds follow the registered state, so mode inputs
    // act immediately without disturbing the duration count.
    assign o_linestate   = linestate_q;
    assign o_se0         = (linestate_q == LS_SE0);
    assign o_se1         = (linestate_q == LS_SE1);
    assign o_j_state     = is_j(linestate_q, i_ls_mode);
    assign o_k_state     = is_k(linestate_q, i_ls_mode);
    assign o_line_change = line_change_q;

    assign o_reset_det   = o_se0 && (dur_q >= RESET_TH) && !i_hs_mode;
    assign o_suspend_det = (i_hs_mode ? o_se0 : o_j_state) && (dur_q >= SUSPEND_TH);

    // dur passes CHIRP_TH exactly once per run, which makes these single pulses.
    assign o_chirp_k = i_chirp_en && !i_rst && o_k_state && (dur_q == CHIRP_TH);
    assign o_chirp_j = i_chirp_en && !i_rst && o_j_state && (dur_q == CHIRP_TH);

endmodule
